// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C write master
//
// Purpose : FSM state encoding and fixed transaction constants used by
//           i2c_write_master.
// Ports   : none (package).

package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_ACK        = 3'd3,
        ST_STOP_LOW   = 3'd4,
        ST_STOP_HIGH  = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic       I2C_WRITE_BIT = 1'b0;
    localparam int         NUM_BYTES     = 3;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(NUM_BYTES - 1);

endpackage

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - single-register I2C write master paced by SCL strobes
//
// Purpose : Performs START, {dev_addr,W}, reg_addr, wr_data, STOP. All SDA
//           activity is timed by the clock generator's cl_low / cl_high strobes.
// Ports   :
//   clock, reset      system clock, synchronous active-high reset
//   scl               free-running SCL from the clock generator
//   cl_low, cl_high   one-cycle strobes at mid SCL-low / mid SCL-high
//   start             one-cycle request, honoured only in IDLE
//   dev_addr, reg_addr, wr_data   transaction fields, latched on start
//   sda_in            SDA pad readback (ACK sampling)
//   sda_oe            1 = pull SDA low
//   scl_out           scl while enabled, otherwise released high
//   busy, done        transaction status (done is a one-cycle pulse)
//   ack_error         sticky NACK flag, cleared by the next accepted start

module i2c_write_master
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       scl,
    input  logic       cl_low,
    input  logic       cl_high,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_out,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    state_t     state_q, state_d;
    logic       sda_q, sda_d;
    logic       scl_en_q, scl_en_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       busy_q, busy_d;
    logic       ack_error_q, ack_error_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] reg_byte_q, reg_byte_d;
    logic [7:0] data_byte_q, data_byte_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sda_q       <= 1'b1;
            scl_en_q    <= 1'b0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            busy_q      <= 1'b0;
            ack_error_q <= 1'b0;
            addr_byte_q <= 8'd0;
            reg_byte_q  <= 8'd0;
            data_byte_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sda_q       <= sda_d;
            scl_en_q    <= scl_en_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            busy_q      <= busy_d;
            ack_error_q <= ack_error_d;
            addr_byte_q <= addr_byte_d;
            reg_byte_q  <= reg_byte_d;
            data_byte_q <= data_byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sda_d       = sda_q;
        scl_en_d    = scl_en_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        busy_d      = busy_q;
        ack_error_d = ack_error_q;
        addr_byte_d = addr_byte_q;
        reg_byte_d  = reg_byte_q;
        data_byte_d = data_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_byte_d = {dev_addr, I2C_WRITE_BIT};
                    reg_byte_d  = reg_addr;
                    data_byte_d = wr_data;
                    ack_error_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT_START;
                end
            end

            // START is SDA falling in mid SCL-high. SCL is enabled at the same
            // strobe, while scl=1, so scl_out never glitches.
            ST_WAIT_START: begin
                if (cl_high) begin
                    sda_d      = 1'b0;
                    scl_en_d   = 1'b1;
                    shift_d    = addr_byte_q;
                    bit_cnt_d  = 3'd7;
                    byte_idx_d = 2'd0;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (cl_low) begin
                    sda_d = shift_q[bit_cnt_q];
                end else if (cl_high) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end

            ST_ACK: begin
                if (cl_low) begin
                    sda_d = 1'b1;
                end else if (cl_high) begin
                    if (sda_in) begin
                        ack_error_d = 1'b1;
                        state_d     = ST_STOP_LOW;
                    end else if (byte_idx_q == LAST_BYTE_IDX) begin
                        state_d = ST_STOP_LOW;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shift_d    = (byte_idx_q == 2'd0) ? reg_byte_q : data_byte_q;
                        bit_cnt_d  = 3'd7;
                        state_d    = ST_DATA;
                    end
                end
            end

            ST_STOP_LOW: begin
                if (cl_low) begin
                    sda_d   = 1'b0;
                    state_d = ST_STOP_HIGH;
                end
            end

            // STOP is SDA rising in mid SCL-high; SCL is released at the same
            // strobe, so scl_out simply stays high.
            ST_STOP_HIGH: begin
                if (cl_high) begin
                    sda_d    = 1'b1;
                    scl_en_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sda_oe    = ~sda_q;
    assign scl_out   = scl_en_q ? scl : 1'b1;
    assign busy      = busy_q;
    assign done      = (state_q == ST_DONE);
    assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - directed self-checking bench for i2c_write_master

module tb_i2c_write_master;

    localparam int P = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wr_data  = 8'd0;
    logic       sda_oe, scl_out, busy, done, ack_error;
    logic       scl, cl_low, cl_high, sda_line;
    logic       slave_pull = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Clock generator stand-in: SCL low for the first half of the period.
    int cnt = 0;
    always @(posedge clock) cnt <= (cnt == P - 1) ? 0 : cnt + 1;
    assign scl     = (cnt >= P / 2);
    assign cl_low  = (cnt == P / 4 - 1);
    assign cl_high = (cnt == 3 * P / 4 - 1);

    assign sda_line = ~(sda_oe | slave_pull);

    i2c_write_master dut (
        .clock     (clock),
        .reset     (reset),
        .scl       (scl),
        .cl_low    (cl_low),
        .cl_high   (cl_high),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .scl_out   (scl_out),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error)
    );

    // Bus monitor and slave model.
    logic cap [0:63];
    int   nbits = 0, nstart = 0, nstop = 0, ndone_t = 0, viol = 0, run = 0;
    int   nack_byte = -1;
    bit   mon_en = 1'b0;
    logic scl_prev = 1'b1, sda_prev = 1'b1;

    always @(negedge clock) begin
        if (mon_en) begin
            if (scl_out && !scl_prev) begin
                if (nbits < 64) cap[nbits] = sda_line;
                nbits++;
            end
            if (!scl_out && scl_prev)
                slave_pull = (nbits % 9 == 8) && (nbits / 9 != nack_byte) && (nbits < 27);
            if (scl_out && scl_prev && (sda_line != sda_prev)) begin
                if (!sda_line) begin
                    nstart++;
                    nbits   = 0;
                    nstop   = 0;
                    ndone_t = 0;
                end else begin
                    nstop++;
                end
            end
            if (done) ndone_t++;
            if (scl_out != scl_prev) begin
                if (run < P / 2) viol++;
                run = 1;
            end else begin
                run++;
            end
        end
        scl_prev = scl_out;
        sda_prev = sda_line;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
        dev_addr = d;
        reg_addr = r;
        wr_data  = w;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    function automatic logic [7:0] get_byte(input int b);
        logic [7:0] v = 8'd0;
        for (int k = 0; k < 8; k++) v = {v[6:0], cap[b * 9 + k]};
        return v;
    endfunction

    task automatic finish_trans(input string tag, input int settle,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input int exp_bits, input int nack_at, input logic exp_err,
                                input int start_before);
        logic [7:0] exp_b [0:2];
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        repeat (settle) @(negedge clock);
        check({tag, "_nbits"}, nbits, exp_bits);
        for (int b = 0; b < 3; b++) begin
            if (b * 9 + 8 < exp_bits && b * 9 + 8 < nbits) begin
                check($sformatf("%s_byte%0d", tag, b), get_byte(b), exp_b[b]);
                check($sformatf("%s_ack%0d", tag, b), cap[b * 9 + 8], (b == nack_at) ? 1'b1 : 1'b0);
            end
        end
        check({tag, "_start_seen"}, nstart - start_before, 1);
        check({tag, "_stop_seen"}, nstop, 1);
        check({tag, "_single_done"}, ndone_t, 1);
        check({tag, "_ack_error"}, ack_error, exp_err);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_scl_sda_integrity"}, viol, 0);
    endtask

    initial begin
        int s0;
        bit hit;

        repeat (3) @(negedge clock);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_scl_out", scl_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_error", ack_error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        repeat (60) @(negedge clock);

        // Scenario 1: happy path.
        s0 = nstart;
        do_start(7'h3C, 8'h10, 8'hA5);
        wait_done("s1");
        finish_trans("s1", 2 * P, 8'h78, 8'h10, 8'hA5, 28, -1, 1'b0, s0);

        // Scenario 3: start while busy is ignored.
        s0 = nstart;
        do_start(7'h3C, 8'h10, 8'hA5);
        repeat (300) @(negedge clock);
        do_start(7'h11, 8'h22, 8'h33);
        wait_done("s3");
        finish_trans("s3", 2 * P, 8'h78, 8'h10, 8'hA5, 28, -1, 1'b0, s0);

        // Scenario 4: reset during byte1 bit 4, in its SCL-high phase.
        do_start(7'h3C, 8'h10, 8'hA5);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clock);
            hit = (nbits == 13) && cl_high;
        end
        check("s4_reached_bit4", hit, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("s4_sda_oe", sda_oe, 1'b0);
        check("s4_scl_out", scl_out, 1'b1);
        check("s4_busy", busy, 1'b0);
        check("s4_done", done, 1'b0);
        repeat (2 * P) @(negedge clock);
        s0 = nstart;
        do_start(7'h50, 8'h02, 8'h3C);
        wait_done("s4b");
        finish_trans("s4b", 2 * P, 8'hA0, 8'h02, 8'h3C, 28, -1, 1'b0, s0);

        // Scenario 2: address NACK.
        nack_byte = 0;
        s0 = nstart;
        do_start(7'h2A, 8'h10, 8'hA5);
        wait_done("s2");
        finish_trans("s2", 0, 8'h54, 8'h00, 8'h00, 10, 0, 1'b1, s0);
        nack_byte = -1;

        // Scenario 5: back-to-back, each start the cycle after the previous done.
        s0 = nstart;
        do_start(7'h3C, 8'h10, 8'h00);
        check("s5a_ack_error_cleared", ack_error, 1'b0);
        wait_done("s5a");
        finish_trans("s5a", 0, 8'h78, 8'h10, 8'h00, 28, -1, 1'b0, s0);
        s0 = nstart;
        do_start(7'h3C, 8'h10, 8'hFF);
        wait_done("s5b");
        finish_trans("s5b", 2 * P, 8'h78, 8'h10, 8'hFF, 28, -1, 1'b0, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Downstream consumer of i2c_clock_generator.
- Performs one complete I2C single-register write: START, device address with W bit, register address byte, data byte, STOP.
- All SDA activity is paced by the generator's one-cycle strobes: cl_low (middle of SCL low phase) and cl_high (middle of SCL high phase).
- Drives open-drain SDA/SCL enables toward the pad level; reports busy, done and NACK to the sensor-control logic above it.

Parameters:
- NUM_BYTES, 3, bytes per transaction (address+W, register, data); fixed, not overridable in this revision.

Ports:
- clock  input  1  system clock; same domain as i2c_clock_generator.
- reset  input  1  synchronous, active-high.
- scl  input  1  free-running SCL from i2c_clock_generator.
- cl_low  input  1  one-cycle strobe, middle of SCL low phase.
- cl_high  input  1  one-cycle strobe, middle of SCL high phase.
- start  input  1  one-cycle request; sampled only in IDLE.
- dev_addr  input  7  7-bit slave address; latched on accepted start.
- reg_addr  input  8  register address; latched on accepted start.
- wr_data  input  8  data byte; latched on accepted start.
- sda_in  input  1  SDA pad readback.
- sda_oe  output  1  1 = pull SDA low.
- scl_out  output  1  SCL to the pad logic: scl when scl_en=1, else 1.
- busy  output  1  high from accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse at end of transaction.
- ack_error  output  1  set on any NACK; cleared on next accepted start.

Behaviour:
- Internal registers:
  - sda_o: SDA level, reset 1; sda_oe = ~sda_o.
  - scl_en: reset 0.
  - shift_byte[7:0], bit_cnt[2:0], byte_idx[1:0].
- Reset values:
  - sda_oe=0, scl_out=1, busy=0, done=0, ack_error=0, state=IDLE.
- Reset mid-transaction: abort immediately to the reset values and release the bus. No STOP is generated.
- Strobe handling:
  - cl_low and cl_high never coincide.
  - A strobe with no action in the current state is ignored.
- Byte order and format:
  - byte0 = {dev_addr,1'b0}, byte1 = reg_addr, byte2 = wr_data.
  - Bits are sent MSB first.
- IDLE:
  - start=1 → latch all three bytes, clear ack_error, busy<=1, → WAIT_START.
  - start while not IDLE is ignored.
- WAIT_START:
  - On cl_high: sda_o<=0 (START, SCL high).
  - scl_en<=1. scl_out stays 1 until the generator drops scl.
  - shift_byte<=byte0, bit_cnt<=7, byte_idx<=0, → DATA.
- DATA:
  - On cl_low: sda_o<=shift_byte[bit_cnt].
  - On cl_high: if bit_cnt==0 → ACK, else bit_cnt<=bit_cnt-1.
- ACK:
  - On cl_low: sda_o<=1 (release SDA).
  - On cl_high, sample sda_in:
    - sda_in=1 → ack_error<=1, → STOP_LOW.
    - sda_in=0 and byte_idx==NUM_BYTES-1 → STOP_LOW.
    - Otherwise → byte_idx++, load the next byte, bit_cnt<=7, → DATA.
- STOP_LOW:
  - On cl_low: sda_o<=0, → STOP_HIGH.
- STOP_HIGH:
  - On cl_high: sda_o<=1 (STOP, SCL high).
  - scl_en<=0, → DONE.
- DONE:
  - done=1 and busy<=0 for one cycle, → IDLE.
  - A start in the cycle after DONE is accepted.
- Timing:
  - Transaction = WAIT_START wait + 27 SCL periods (3×9 bits) + 1 stop period.
  - Total ≤ 29×PERIOD clocks after start.
- SCL behaviour:
  - No glitch on scl_out at enable: scl_en rises while scl=1.
  - At disable, scl_en falls at cl_high, so scl_out remains 1.

Decomposition:
- Shared package i2c_pkg:
  - state encoding (IDLE, WAIT_START, DATA, ACK, STOP_LOW, STOP_HIGH, DONE).
  - I2C_WRITE_BIT=1'b0 and NUM_BYTES.
- No sub-module; the FSM and shift register are single-module (~150 lines).
- Top level instantiates i2c_clock_generator alongside this block, sharing clock and reset.

Test Plan:
- Generator PERIOD=1000 (cl_low at counter 249, cl_high at 749).
- Scenario 1, happy path:
  - Stimulus: start with dev 0x3C, reg 0x10, data 0xA5; slave model ACKs all bytes.
  - Response: SDA bits sampled on scl rises = 0x78,ACK,0x10,ACK,0xA5,ACK.
  - START seen (SDA fall with scl_out=1) and STOP seen (SDA rise with scl_out=1).
  - done pulses once, ack_error=0, busy low after done.
- Scenario 2, address NACK:
  - Stimulus: slave releases SDA on the first ACK.
  - Response: ack_error=1; no further data bits; STOP issued within 1 SCL period; done pulses.
- Scenario 3, start while busy:
  - Stimulus: second start with dev 0x11 mid-transfer.
  - Response: ignored; bytes remain 0x78/0x10/0xA5; single done.
- Scenario 4, reset mid-byte:
  - Stimulus: assert reset during byte1 bit 4.
  - Response: next cycle sda_oe=0, scl_out=1, busy=0, done=0.
  - A following start yields a normal transaction.
- Scenario 5, back-to-back transactions:
  - Stimulus: start the cycle after done, with data 0x00 then 0xFF.
  - Response: both transfers correct; ack_error cleared at the second start.
- Scenario 6, SCL integrity:
  - Stimulus: monitor throughout scenarios 1–5.
  - Response: scl_out never pulses shorter than PERIOD/2; SDA changes only while scl_out=0, except at START/STOP.
